// File: rtl/led_seq_pkg.sv
// Shared state encoding and entry patterns for the LED sequencer.
// Also provides the mode rotation order and per-state entry pattern lookup.
package led_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_COUNT = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_BLINK = 2'd3;

  localparam logic [3:0] PAT_COUNT0 = 4'h0;
  localparam logic [3:0] PAT_SHIFT0 = 4'b0001;
  localparam logic [3:0] PAT_BLINK0 = 4'hF;

  // Rotation order used by both auto-advance and mode_next.
  function automatic state_t next_mode(input state_t s);
    case (s)
      ST_COUNT: next_mode = ST_SHIFT;
      ST_SHIFT: next_mode = ST_BLINK;
      default:  next_mode = ST_COUNT;
    endcase
  endfunction

  function automatic logic [3:0] entry_pat(input state_t s);
    case (s)
      ST_COUNT: entry_pat = PAT_COUNT0;
      ST_SHIFT: entry_pat = PAT_SHIFT0;
      ST_BLINK: entry_pat = PAT_BLINK0;
      default:  entry_pat = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Free-running prescaler with synchronous clear and enable.
// Terminal count is flagged while the counter sits at all-ones.
module led_seq_prescaler #(
  parameter int PRESCALE_W = 22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [PRESCALE_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + PRESCALE_W'(1);
    end
  end

  assign o_tc = &r_cnt;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: cycles 4 LEDs through count / walk / blink modes,
// stepping on a prescaled tick and advancing mode after a fixed step count.
//
// state | meaning
// IDLE  | disabled, LEDs dark
// COUNT | binary up-count on each tick
// SHIFT | single lit LED rotating left
// BLINK | all LEDs toggling together
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int PRESCALE_W     = 22,
  parameter int STEPS_PER_MODE = 16,
  parameter int STEP_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode_next,
  output logic [3:0] io_led,
  output logic [1:0] mode,
  output logic       tick
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS_PER_MODE - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_led;
  logic [3:0]        w_led_nxt;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_nxt;
  logic              r_tick;
  logic              w_tick_nxt;
  logic              w_tc;
  logic              w_active;
  logic              w_tick_i;
  logic              w_pre_clr;

  assign w_active  = en && (r_state != ST_IDLE);
  assign w_tick_i  = w_active && w_tc;
  assign w_pre_clr = (w_state_nxt != r_state);

  led_seq_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_pre_clr),
    .i_en  (w_active),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_step_nxt  = r_step;
    w_tick_nxt  = 1'b0;
    if (r_state == ST_IDLE) begin
      w_led_nxt  = 4'h0;
      w_step_nxt = '0;
      if (en) begin
        w_state_nxt = ST_COUNT;
        w_led_nxt   = PAT_COUNT0;
      end
    end else if (!en) begin
      w_state_nxt = ST_IDLE;
      w_led_nxt   = 4'h0;
      w_step_nxt  = '0;
    end else if (mode_next) begin
      // A coincident tick is swallowed here so the skip never double-advances.
      w_state_nxt = next_mode(r_state);
      w_led_nxt   = entry_pat(w_state_nxt);
      w_step_nxt  = '0;
    end else if (w_tick_i) begin
      w_tick_nxt = 1'b1;
      if (r_step == LAST_STEP) begin
        w_state_nxt = next_mode(r_state);
        w_led_nxt   = entry_pat(w_state_nxt);
        w_step_nxt  = '0;
      end else begin
        w_step_nxt = r_step + STEP_W'(1);
        case (r_state)
          ST_COUNT: w_led_nxt = r_led + 4'd1;
          ST_SHIFT: w_led_nxt = {r_led[2:0], r_led[3]};
          default:  w_led_nxt = ~r_led;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_led   <= 4'h0;
      r_step  <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_step  <= w_step_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign io_led = r_led;
  assign mode   = r_state;
  assign tick   = r_tick;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: stimulus queues expected output events
// (edge index, mode, LEDs, tick); a negedge monitor pops and compares them.
module tb_led_seq_ctrl;

  typedef struct {
    int         edge_n;
    logic [1:0] mode;
    logic [3:0] led;
    logic       tick;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       mode_next = 1'b0;
  logic [3:0] io_led;
  logic [1:0] mode;
  logic       tick;

  logic       en2 = 1'b1;
  logic       mode_next2 = 1'b0;
  logic [3:0] io_led2;
  logic [1:0] mode2;
  logic       tick2;

  int   n_checks = 0;
  int   n_pass = 0;
  int   pos = -1;
  bit   mon_on = 1'b0;
  ev_t  exp_q[$];
  logic [5:0] prev = 6'h0;

  always #5 clk = ~clk;

  led_seq_ctrl #(.PRESCALE_W(2), .STEPS_PER_MODE(3), .STEP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode_next(mode_next),
    .io_led(io_led), .mode(mode), .tick(tick)
  );

  // Longer mode so the binary count wraps F->0 inside COUNT.
  led_seq_ctrl #(.PRESCALE_W(2), .STEPS_PER_MODE(20), .STEP_W(8)) dut_long (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode_next(mode_next2),
    .io_led(io_led2), .mode(mode2), .tick(tick2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input int e, input int m, input int l, input int t);
    ev_t ev;
    ev.edge_n = e;
    ev.mode   = 2'(m);
    ev.led    = 4'(l);
    ev.tick   = 1'(t);
    exp_q.push_back(ev);
  endtask

  task automatic to_edge(input int k);
    while (pos < k) begin
      @(posedge clk);
      #1;
      pos++;
    end
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_on && (tick === 1'b1 || {mode, io_led} !== prev)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event_edge", pos, -1);
      end else begin
        e = exp_q.pop_front();
        check("ev_edge", pos, e.edge_n);
        check("ev_mode", int'(mode), int'(e.mode));
        check("ev_led",  int'(io_led), int'(e.led));
        check("ev_tick", int'(tick), int'(e.tick));
      end
    end
    prev = {mode, io_led};
  end

  initial begin : long_mode_checks
    int k;
    k = -1;
    @(posedge rst_n);
    while (k < 64) begin
      @(posedge clk);
      #2;
      k++;
      if (k == 56) begin
        check("wrap_led_E", int'(io_led2), 14);
        check("wrap_tick_E", int'(tick2), 1);
      end
      if (k == 57) check("wrap_tick_low", int'(tick2), 0);
      if (k == 60) begin
        check("wrap_led_F", int'(io_led2), 15);
        check("wrap_tick_F", int'(tick2), 1);
      end
      if (k == 64) begin
        check("wrap_led_0", int'(io_led2), 0);
        check("wrap_tick_0", int'(tick2), 1);
        check("wrap_mode", int'(mode2), 1);
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int ev_edge[10] = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 36};
    int ev_mode[10] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 1};
    int ev_led[10]  = '{0, 1, 2, 1, 2, 4, 15, 0, 15, 0};
    int ev_tick[10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_mode", int'(mode), 0);
      check("rst_led",  int'(io_led), 0);
      check("rst_tick", int'(tick), 0);
    end

    rst_n  = 1'b1;
    prev   = 6'h0;
    mon_on = 1'b1;
    for (int i = 0; i < 10; i++) push(ev_edge[i], ev_mode[i], ev_led[i], ev_tick[i]);

    // mode_next coincident with the COUNT tick at edge 40
    to_edge(39);
    mode_next = 1'b1;
    push(40, 2, 1, 0);
    push(44, 2, 2, 1);
    to_edge(40);
    mode_next = 1'b0;

    // drop enable mid-SHIFT, then re-enable
    to_edge(45);
    en = 1'b0;
    push(46, 0, 0, 0);
    to_edge(46);
    en = 1'b1;
    push(47, 1, 0, 0);
    push(51, 1, 1, 1);
    push(55, 1, 2, 1);
    push(59, 2, 1, 1);
    push(63, 2, 2, 1);
    push(67, 2, 4, 1);
    push(71, 3, 15, 1);

    // reset mid-BLINK with mode_next asserted
    to_edge(72);
    rst_n     = 1'b0;
    mode_next = 1'b1;
    push(73, 0, 0, 0);
    to_edge(73);
    check("midrst_mode", int'(mode), 0);
    check("midrst_led",  int'(io_led), 0);
    check("midrst_tick", int'(tick), 0);
    rst_n     = 1'b1;
    en        = 1'b0;
    mode_next = 1'b0;

    to_edge(80);
    check("idle_mode", int'(mode), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
